uart_rx_fifo_if: RTL and testbench

- UART receiver front end for the top-level command path.
- Deserialises 8N1 frames from the board `rx` pin and presents each byte on a valid/ready handshake.
- Consumer is the downstream ASCII command decoder ('R', 'X', mode/button equivalents).
- Flags false starts, framing errors and overruns so the decoder never sees corrupt bytes.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/baud_tick_gen.sv | 33 +++
 rtl/uart_rx_fifo_if.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_fifo_if.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver FSM encoding, the sample-phase landmarks and the tick-divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } rx_state_e;

    // Phase landmarks within one bit period of OVERSAMPLE ticks.
    localparam logic [3:0] MID_PHASE  = 4'd7;
    localparam logic [3:0] LAST_PHASE = 4'd15;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running sample-tick generator: emits a one-clock pulse every DIV clocks.
// The counter never resynchronises to the line; receive-side jitter of up to one tick is expected.
module baud_tick_gen #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned   CntW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntMax) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_rx_fifo_if.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
// Reports false starts silently, and framing errors and overruns as one-cycle pulses.
module uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);

    logic       tick;
    logic       rx_meta_q, rx_sync_q;
    rx_state_e  state_d, state_q;
    logic [3:0] phase_d, phase_q;
    logic [2:0] bit_idx_d, bit_idx_q;
    logic [7:0] shift_d, shift_q;
    logic [7:0] data_d, data_q;
    logic       valid_d, valid_q;
    logic       frame_err_d, frame_err_q;
    logic       overrun_d, overrun_q;
    logic       byte_done;
    logic       stop_bad;

    baud_tick_gen #(
        .DIV (DIV)
    ) u_baud_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    phase_d = '0;
                    state_d = StStart;
                end
            end

            StStart: begin
                if (tick) begin
                    if (phase_q == MID_PHASE) begin
                        if (rx_sync_q) begin
                            state_d = StIdle;
                        end else begin
                            phase_d   = '0;
                            bit_idx_d = '0;
                            state_d   = StData;
                        end
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
            end

            StData: begin
                if (tick) begin
                    // Phase wraps 15 -> 0, so each bit is sampled 16 ticks after the last.
                    phase_d = phase_q + 4'd1;
                    if (phase_q == LAST_PHASE) begin
                        shift_d[bit_idx_q] = rx_sync_q;
                        bit_idx_d          = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = StStop;
                        end
                    end
                end
            end

            StStop: begin
                if (tick) begin
                    phase_d = phase_q + 4'd1;
                    if (phase_q == LAST_PHASE) begin
                        if (rx_sync_q) begin
                            byte_done = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            stop_bad = 1'b1;
                            state_d  = StWaitHigh;
                        end
                    end
                end
            end

            StWaitHigh: begin
                // A held-low line (break) must not start a new frame.
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = stop_bad;

        if (byte_done) begin
            // A byte leaving in the same cycle frees the slot for the new one.
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = (state_q != StIdle);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo_if.sv
// Self-checking bench for uart_rx_fifo_if at a scaled line rate (64 clk per bit).
// A transaction-level model predicts accepted bytes and flag counts; a monitor checks every handshake.
module tb_uart_rx_fifo_if;

    localparam int unsigned CLK_FREQ = 6_400_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned BIT_CLK  = CLK_FREQ / BAUD;
    localparam longint      LAT_NOM  = (BIT_CLK * 19) / 2;
    localparam longint      LAT_MIN  = LAT_NOM - 8;
    localparam longint      LAT_MAX  = LAT_NOM + 12;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int         n_tests = 0;
    int         n_fail  = 0;

    // Model state: bytes the consumer must receive, the byte parked in the holding slot, flag counts.
    logic [7:0] acc_q[$];
    bit         held = 0;
    logic [7:0] held_data = '0;
    int         fe_exp = 0;
    int         ov_exp = 0;

    // Observed by the monitor.
    int         fe_seen = 0;
    int         ov_seen = 0;
    int         acc_cnt = 0;
    logic [7:0] last_acc = '0;
    time        t_fall = 0;
    bit         valid_prev = 0;
    logic [7:0] exp_b;
    longint     lat;

    logic [7:0] rb;
    bit         rok;

    uart_rx_fifo_if #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx     = 1'b0;
        t_fall = $time;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(BIT_CLK);
        end
        rx = stop_bit;
        wait_clk(BIT_CLK - 1);
        if (stop_bit) check("busy_low_end_of_stop", {31'd0, rx_busy}, 32'd0);
        wait_clk(1);
    endtask

    // Predicts the outcome of a good frame; rx_ready is held constant across each frame.
    task automatic model_good(input logic [7:0] b);
        if (rx_ready) begin
            acc_q.push_back(b);
        end else if (held) begin
            ov_exp++;
        end else begin
            held      = 1'b1;
            held_data = b;
        end
    endtask

    task automatic set_ready(input logic r);
        if (r && !rx_ready && held) begin
            acc_q.push_back(held_data);
            held = 1'b0;
        end
        rx_ready = r;
    endtask

    task automatic checkpoint(input string tag);
        wait_clk(6);
        check({tag, "_valid"}, {31'd0, rx_valid}, {31'd0, held});
        if (held) check({tag, "_data"}, {24'd0, rx_data}, {24'd0, held_data});
        check({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
        check({tag, "_frame_err_count"}, fe_seen, fe_exp);
        check({tag, "_overrun_count"}, ov_seen, ov_exp);
        check({tag, "_pending_accepts"}, acc_q.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_rx_busy"}, {31'd0, rx_busy}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    // Monitor: every handshake must deliver the next predicted byte; every valid rise must
    // land about 9.5 bit times after the start edge; pulses are counted per high cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rx_valid && rx_ready) begin
                    if (acc_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL accept_unexpected: got data 0x%02h, expected no handshake",
                                 rx_data);
                    end else begin
                        exp_b = acc_q.pop_front();
                        check("accept_data", {24'd0, rx_data}, {24'd0, exp_b});
                        last_acc = rx_data;
                        acc_cnt++;
                    end
                end
                if (rx_valid && !valid_prev) begin
                    lat = longint'(($time - t_fall) / 10);
                    n_tests++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        n_fail++;
                        $display("FAIL valid_latency: got %0d clk, expected %0d..%0d clk",
                                 lat, LAT_MIN, LAT_MAX);
                    end
                end
                if (frame_err) fe_seen++;
                if (overrun) ov_seen++;
            end
            valid_prev = rx_valid;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        wait_clk(5);
        check_all_zero("reset");
        rst = 1'b1;
        wait_clk(10);

        // Single 'R'.
        model_good(8'h52);
        send_frame(8'h52, 1'b1);
        checkpoint("single_r");
        check("single_r_last", {24'd0, last_acc}, 32'h52);
        check("single_r_count", acc_cnt, 32'd1);

        // Back-to-back 'R','R','X'.
        model_good(8'h52);
        send_frame(8'h52, 1'b1);
        model_good(8'h52);
        send_frame(8'h52, 1'b1);
        model_good(8'h58);
        send_frame(8'h58, 1'b1);
        checkpoint("rrx");
        check("rrx_last", {24'd0, last_acc}, 32'h58);
        check("rrx_count", acc_cnt, 32'd4);

        // Glitch shorter than half a bit.
        rx     = 1'b0;
        t_fall = $time;
        wait_clk(10);
        check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
        wait_clk(8);
        rx = 1'b1;
        wait_clk(BIT_CLK);
        checkpoint("glitch");

        // Framing error followed by a break, then a good frame.
        send_frame(8'h58, 1'b0);
        fe_exp++;
        wait_clk(3 * BIT_CLK);
        check("break_busy_held", {31'd0, rx_busy}, 32'd1);
        check("break_single_ferr", fe_seen, 32'd1);
        check("break_no_valid", {31'd0, rx_valid}, 32'd0);
        rx = 1'b1;
        checkpoint("ferr");
        wait_clk(BIT_CLK);
        model_good(8'h52);
        send_frame(8'h52, 1'b1);
        checkpoint("after_ferr");
        check("after_ferr_last", {24'd0, last_acc}, 32'h52);

        // Overrun with the consumer stalled.
        set_ready(1'b0);
        wait_clk(4);
        model_good(8'h52);
        send_frame(8'h52, 1'b1);
        checkpoint("ovr_first");
        model_good(8'h58);
        send_frame(8'h58, 1'b1);
        checkpoint("ovr_second");
        check("ovr_pulses", ov_seen, 32'd1);
        check("ovr_kept_old", {24'd0, rx_data}, 32'h52);
        set_ready(1'b1);
        checkpoint("ovr_drain");
        check("ovr_drain_last", {24'd0, last_acc}, 32'h52);
        check("ovr_drain_count", acc_cnt, 32'd6);

        // Reset during data bit 4 of 0x52.
        rb     = 8'h52;
        rx     = 1'b0;
        t_fall = $time;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            wait_clk(BIT_CLK);
        end
        rx = rb[4];
        wait_clk(BIT_CLK / 2);
        rst = 1'b0;
        wait_clk(10);
        check_all_zero("mid_reset");
        rx = 1'b1;
        wait_clk(10);
        rst = 1'b1;
        wait_clk(11 * BIT_CLK);
        checkpoint("post_reset");
        model_good(8'h58);
        send_frame(8'h58, 1'b1);
        checkpoint("post_reset_frame");
        check("post_reset_last", {24'd0, last_acc}, 32'h58);

        // Randomized traffic: random bytes, stalls and occasional framing errors.
        for (int k = 0; k < 30; k++) begin
            set_ready(1'($urandom_range(0, 1)));
            wait_clk(2 + $urandom_range(0, 40));
            rb  = 8'($urandom);
            rok = ($urandom_range(0, 7) != 0);
            if (rok) model_good(rb);
            send_frame(rb, rok);
            if (!rok) begin
                wait_clk($urandom_range(0, 150));
                rx = 1'b1;
                fe_exp++;
            end
            checkpoint("rand");
        end
        set_ready(1'b1);
        checkpoint("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
